// File: rtl/emulib_ctrlbus_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the emulator control-bus initiator.
package emulib_ctrlbus_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_ISSUE = 2'd1,
      W_RESP  = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_ISSUE = 2'd1,
      R_RESP  = 2'd2
   } r_state_e;

endpackage

// File: rtl/ctrlbus_hold_reg.sv
// One-deep valid/ready holding register; full_c/data_c already include a capture happening this cycle.
module ctrlbus_hold_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clr,
   output logic             full_c,
   output logic [WIDTH-1:0] data_c
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clr) begin
         full_d = 1'b0;
      end else if (in_valid && in_ready) begin
         full_d = 1'b1;
         data_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_c = full_d;
   assign data_c = data_d;

endmodule

// File: rtl/axilite_to_ctrlbus.sv
// AXI4-Lite slave that turns each write/read into one single-cycle ctrl-bus strobe.
// Write and read paths run independently, one outstanding transaction each.
module axilite_to_ctrlbus
   import emulib_ctrlbus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_axilite_awvalid,
   output logic                    s_axilite_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axilite_awaddr,
   input  logic                    s_axilite_wvalid,
   output logic                    s_axilite_wready,
   input  logic [DATA_WIDTH-1:0]   s_axilite_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axilite_wstrb,
   output logic                    s_axilite_bvalid,
   input  logic                    s_axilite_bready,
   output logic [1:0]              s_axilite_bresp,
   input  logic                    s_axilite_arvalid,
   output logic                    s_axilite_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axilite_araddr,
   output logic                    s_axilite_rvalid,
   input  logic                    s_axilite_rready,
   output logic [DATA_WIDTH-1:0]   s_axilite_rdata,
   output logic [1:0]              s_axilite_rresp,
   output logic                    m_ctrl_wen,
   output logic [ADDR_WIDTH-1:0]   m_ctrl_waddr,
   output logic [DATA_WIDTH-1:0]   m_ctrl_wdata,
   output logic                    m_ctrl_ren,
   output logic [ADDR_WIDTH-1:0]   m_ctrl_raddr,
   input  logic [DATA_WIDTH-1:0]   m_ctrl_rdata
);

   localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8;
   localparam int unsigned W_HOLD_WIDTH = DATA_WIDTH + STRB_WIDTH;

   w_state_e                w_state_q, w_state_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic                    bvalid_q, bvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   r_state_e                r_state_q, r_state_d;
   logic                    arready_q, arready_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    ren_q, ren_d;
   logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;

   logic                    hold_clr_c;
   logic                    aw_full_c, w_full_c;
   logic [ADDR_WIDTH-1:0]   aw_addr_c;
   logic [W_HOLD_WIDTH-1:0] w_hold_c;
   logic [DATA_WIDTH-1:0]   w_data_c;
   logic [STRB_WIDTH-1:0]   w_strb_c;

   ctrlbus_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s_axilite_awvalid),
      .in_ready (awready_q),
      .in_data  (s_axilite_awaddr),
      .clr      (hold_clr_c),
      .full_c   (aw_full_c),
      .data_c   (aw_addr_c)
   );

   ctrlbus_hold_reg #(.WIDTH(W_HOLD_WIDTH)) u_w_hold (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s_axilite_wvalid),
      .in_ready (wready_q),
      .in_data  ({s_axilite_wstrb, s_axilite_wdata}),
      .clr      (hold_clr_c),
      .full_c   (w_full_c),
      .data_c   (w_hold_c)
   );

   assign w_data_c = w_hold_c[DATA_WIDTH-1:0];
   assign w_strb_c = w_hold_c[W_HOLD_WIDTH-1:DATA_WIDTH];

   // Write path: decide on the edge that completes the pair so wen lands one cycle after the last handshake.
   always_comb begin
      w_state_d  = w_state_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      hold_clr_c = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_full_c && w_full_c) begin
               w_state_d = W_ISSUE;
               if (&w_strb_c) begin
                  wen_d   = 1'b1;
                  waddr_d = aw_addr_c;
                  wdata_d = w_data_c;
                  bresp_d = RESP_OKAY;
               end else begin
                  bresp_d = RESP_SLVERR;
               end
            end
         end
         W_ISSUE: begin
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
         end
         W_RESP: begin
            if (s_axilite_bready) begin
               bvalid_d   = 1'b0;
               hold_clr_c = 1'b1;
               w_state_d  = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE) && !aw_full_c;
      wready_d  = (w_state_d == W_IDLE) && !w_full_c;
   end

   // Read path: endpoint data is combinational during the ren cycle and captured at its end.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      ren_d     = 1'b0;
      raddr_d   = raddr_q;
      case (r_state_q)
         R_IDLE: begin
            if (s_axilite_arvalid && arready_q) begin
               raddr_d   = s_axilite_araddr;
               ren_d     = 1'b1;
               r_state_d = R_ISSUE;
            end
         end
         R_ISSUE: begin
            rdata_d   = m_ctrl_rdata;
            rvalid_d  = 1'b1;
            r_state_d = R_RESP;
         end
         R_RESP: begin
            if (s_axilite_rready) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         ren_q     <= 1'b0;
         raddr_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         ren_q     <= ren_d;
         raddr_q   <= raddr_d;
      end
   end

   assign s_axilite_awready = awready_q;
   assign s_axilite_wready  = wready_q;
   assign s_axilite_bvalid  = bvalid_q;
   assign s_axilite_bresp   = bresp_q;
   assign s_axilite_arready = arready_q;
   assign s_axilite_rvalid  = rvalid_q;
   assign s_axilite_rdata   = rdata_q;
   assign s_axilite_rresp   = RESP_OKAY;
   assign m_ctrl_wen        = wen_q;
   assign m_ctrl_waddr      = waddr_q;
   assign m_ctrl_wdata      = wdata_q;
   assign m_ctrl_ren        = ren_q;
   assign m_ctrl_raddr      = raddr_q;

endmodule

// File: tb/tb_axilite_to_ctrlbus.sv
// Scenario bench for axilite_to_ctrlbus: directed cases plus randomized traffic against a memory model.
module tb_axilite_to_ctrlbus;

   logic        clk;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata;
   logic        wen, ren;
   logic [31:0] waddr, wdat_o, raddr, ep_rdata;

   int checks = 0;
   int passes = 0;
   int wen_cnt = 0;
   int ren_cnt = 0;

   logic [31:0] mem_ep    [0:255];
   logic [31:0] mem_model [0:255];
   logic        ep_force;
   logic [31:0] ep_force_val;
   logic [138:0] outs_c;

   axilite_to_ctrlbus #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .s_axilite_awvalid(awvalid), .s_axilite_awready(awready), .s_axilite_awaddr(awaddr),
      .s_axilite_wvalid(wvalid), .s_axilite_wready(wready), .s_axilite_wdata(wdata),
      .s_axilite_wstrb(wstrb),
      .s_axilite_bvalid(bvalid), .s_axilite_bready(bready), .s_axilite_bresp(bresp),
      .s_axilite_arvalid(arvalid), .s_axilite_arready(arready), .s_axilite_araddr(araddr),
      .s_axilite_rvalid(rvalid), .s_axilite_rready(rready), .s_axilite_rdata(rdata),
      .s_axilite_rresp(rresp),
      .m_ctrl_wen(wen), .m_ctrl_waddr(waddr), .m_ctrl_wdata(wdat_o),
      .m_ctrl_ren(ren), .m_ctrl_raddr(raddr), .m_ctrl_rdata(ep_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(int i);
      return (32'(i) * 32'h0001_0003) ^ 32'hC0DE_0000;
   endfunction

   // Endpoint: register file written by wen, read combinationally (reads see the pre-write value).
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem_ep[i] <= init_val(i);
      end else if (wen) begin
         mem_ep[waddr[9:2]] <= wdat_o;
      end
   end

   always_comb ep_rdata = ep_force ? ep_force_val : mem_ep[raddr[9:2]];

   always @(posedge clk) begin
      if (!rst) begin
         if (wen) wen_cnt++;
         if (ren) ren_cnt++;
      end
   end

   assign outs_c = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
                    wen, waddr, wdat_o, ren, raddr};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) mem_model[i] = init_val(i);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (!(awready && wready && arready) && t < 50) begin
         step();
         t++;
      end
      checks++;
      if (!(awready && wready && arready))
         $display("FAIL %s_idle_timeout aw=%0b w=%0b ar=%0b exp=111", tag, awready, wready, arready);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; ep_force = 0; ep_force_val = 0;
      repeat (3) step();
      checks++;
      if (outs_c !== '0) $display("FAIL reset_outputs got=%h exp=0", outs_c);
      else passes++;
      rst = 1'b0;
      model_reset();
      wait_idle("reset");
   endtask

   task automatic test_write_same_cycle();
      int w0;
      wait_idle("t1");
      w0 = wen_cnt;
      awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      step();
      awvalid = 0; wvalid = 0;
      checks++;
      if (wen !== 1'b1 || waddr !== 32'h10 || wdat_o !== 32'hDEADBEEF)
         $display("FAIL t1_wen wen=%0b addr=%h data=%h exp=1/10/deadbeef", wen, waddr, wdat_o);
      else passes++;
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0)
         $display("FAIL t1_busy aw=%0b w=%0b b=%0b exp=000", awready, wready, bvalid);
      else passes++;
      step();
      checks++;
      if (wen !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00)
         $display("FAIL t1_bresp wen=%0b bvalid=%0b bresp=%0b exp=0/1/00", wen, bvalid, bresp);
      else passes++;
      bready = 1;
      step();
      bready = 0;
      checks++;
      if (bvalid !== 1'b0 || wen_cnt - w0 != 1)
         $display("FAIL t1_done bvalid=%0b wens=%0d exp=0/1", bvalid, wen_cnt - w0);
      else passes++;
      mem_model[8'h04] = 32'hDEADBEEF;
   endtask

   task automatic test_w_first();
      int w0;
      wait_idle("t2");
      w0 = wen_cnt;
      wvalid = 1; wdata = 32'hA5A5_0F0F; wstrb = 4'hF;
      step();
      wvalid = 0;
      checks++;
      if (wready !== 1'b0 || awready !== 1'b1)
         $display("FAIL t2_wready wready=%0b awready=%0b exp=0/1", wready, awready);
      else passes++;
      step();
      step();
      awvalid = 1; awaddr = 32'h14;
      checks++;
      if (wen_cnt != w0) $display("FAIL t2_early_wen wens=%0d exp=0", wen_cnt - w0);
      else passes++;
      step();
      awvalid = 0;
      checks++;
      if (wen !== 1'b1 || waddr !== 32'h14 || wdat_o !== 32'hA5A5_0F0F)
         $display("FAIL t2_wen wen=%0b addr=%h data=%h exp=1/14/a5a50f0f", wen, waddr, wdat_o);
      else passes++;
      step();
      bready = 1;
      step();
      bready = 0;
      checks++;
      if (wen_cnt - w0 != 1) $display("FAIL t2_single_wen wens=%0d exp=1", wen_cnt - w0);
      else passes++;
      mem_model[8'h05] = 32'hA5A5_0F0F;
   endtask

   task automatic test_partial_strobe();
      int w0;
      wait_idle("t3");
      w0 = wen_cnt;
      awvalid = 1; awaddr = 32'h70; wvalid = 1; wdata = 32'h1111_2222; wstrb = 4'h3;
      step();
      awvalid = 0; wvalid = 0;
      step();
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b10)
         $display("FAIL t3_slverr bvalid=%0b bresp=%0b exp=1/10", bvalid, bresp);
      else passes++;
      bready = 1;
      step();
      bready = 0;
      checks++;
      if (wen_cnt != w0) $display("FAIL t3_no_wen wens=%0d exp=0", wen_cnt - w0);
      else passes++;
      wait_idle("t3b");
      awvalid = 1; awaddr = 32'h70; wvalid = 1; wdata = 32'h3333_4444; wstrb = 4'hF;
      step();
      awvalid = 0; wvalid = 0;
      checks++;
      if (wen !== 1'b1 || wdat_o !== 32'h3333_4444)
         $display("FAIL t3_full_wen wen=%0b data=%h exp=1/33334444", wen, wdat_o);
      else passes++;
      step();
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00)
         $display("FAIL t3_okay bvalid=%0b bresp=%0b exp=1/00", bvalid, bresp);
      else passes++;
      bready = 1;
      step();
      bready = 0;
      mem_model[8'h1C] = 32'h3333_4444;
   endtask

   task automatic test_read_stall();
      int bad;
      wait_idle("t4");
      ep_force = 1; ep_force_val = 32'h1234_5678;
      arvalid = 1; araddr = 32'h20;
      step();
      arvalid = 0;
      checks++;
      if (ren !== 1'b1 || raddr !== 32'h20 || rvalid !== 1'b0)
         $display("FAIL t4_ren ren=%0b raddr=%h rvalid=%0b exp=1/20/0", ren, raddr, rvalid);
      else passes++;
      step();
      ep_force_val = 32'hFFFF_0000;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00 || ren !== 1'b0)
         $display("FAIL t4_rvalid rvalid=%0b rdata=%h rresp=%0b ren=%0b exp=1/12345678/00/0",
                  rvalid, rdata, rresp, ren);
      else passes++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || arready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL t4_stall_stable bad_cycles=%0d exp=0", bad);
      else passes++;
      rready = 1;
      step();
      rready = 0;
      ep_force = 0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1)
         $display("FAIL t4_done rvalid=%0b arready=%0b exp=0/1", rvalid, arready);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int nwen, nren, nboth, nb, nr, ndone, wd_bad, rd_bad;
      logic [31:0] sent;
      logic hs;
      nwen = 0; nren = 0; nboth = 0; nb = 0; nr = 0; ndone = 0; wd_bad = 0; rd_bad = 0;
      sent = 0;
      wait_idle("t5");
      bready = 1; rready = 1;
      awvalid = 1; awaddr = 32'h30; wvalid = 1; wstrb = 4'hF; wdata = $urandom;
      arvalid = 1; araddr = 32'h40;
      for (int i = 0; i < 12; i++) begin
         if (wen) begin
            nwen++;
            if (wdat_o !== sent || waddr !== 32'h30) wd_bad++;
         end
         if (ren) nren++;
         if (wen && ren) nboth++;
         if (bvalid) nb++;
         if (rvalid) begin
            nr++;
            if (rdata !== mem_model[8'h10]) rd_bad++;
         end
         if (bvalid && rvalid) ndone++;
         hs = awvalid && awready && wready;
         if (hs) sent = wdata;
         step();
         if (hs) wdata = $urandom;
      end
      awvalid = 0; wvalid = 0; arvalid = 0;
      checks++;
      if (nwen != 4 || nren != 4 || nboth != 4)
         $display("FAIL t5_strobes wen=%0d ren=%0d same=%0d exp=4/4/4", nwen, nren, nboth);
      else passes++;
      checks++;
      if (nb != 4 || nr != 4 || ndone != 4)
         $display("FAIL t5_resps b=%0d r=%0d same=%0d exp=4/4/4", nb, nr, ndone);
      else passes++;
      checks++;
      if (wd_bad != 0 || rd_bad != 0)
         $display("FAIL t5_data wdata_bad=%0d rdata_bad=%0d exp=0/0", wd_bad, rd_bad);
      else passes++;
      bready = 0; rready = 0;
      mem_model[8'h0C] = sent;
   endtask

   task automatic test_random();
      int w0, k, d_aw, d_w, bdly, bad;
      logic aw_done, w_done, aw_hs, w_hs, full;
      logic [31:0] a, d;
      logic [3:0]  s;
      bad = 0;
      for (int it = 0; it < 24; it++) begin
         a = $urandom & 32'h0000_03FC;
         d = $urandom;
         s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
         full = (s == 4'hF);
         d_aw = $urandom_range(0, 3); d_w = $urandom_range(0, 3); bdly = $urandom_range(0, 3);
         wait_idle("rnd");
         w0 = wen_cnt; aw_done = 0; w_done = 0; k = 0;
         awaddr = a; wdata = d; wstrb = s;
         while (!(aw_done && w_done) && k < 20) begin
            awvalid = (k >= d_aw) && !aw_done;
            wvalid  = (k >= d_w) && !w_done;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            k++;
         end
         awvalid = 0; wvalid = 0;
         if (wen !== full || (full && (waddr !== a || wdat_o !== d))) bad++;
         step();
         if (bvalid !== 1'b1 || bresp !== (full ? 2'b00 : 2'b10)) bad++;
         repeat (bdly) step();
         if (bvalid !== 1'b1) bad++;
         bready = 1;
         step();
         bready = 0;
         if (wen_cnt - w0 != (full ? 1 : 0)) bad++;
         if (full) mem_model[a[9:2]] = d;
         a = $urandom & 32'h0000_03FC;
         wait_idle("rnd_rd");
         arvalid = 1; araddr = a;
         step();
         arvalid = 0;
         if (ren !== 1'b1 || raddr !== a) bad++;
         step();
         checks++;
         if (rvalid !== 1'b1 || rdata !== mem_model[a[9:2]])
            $display("FAIL rnd_read it=%0d addr=%h got=%h exp=%h", it, a, rdata, mem_model[a[9:2]]);
         else passes++;
         rready = 1;
         step();
         rready = 0;
      end
      checks++;
      if (bad != 0) $display("FAIL rnd_write_path bad=%0d exp=0", bad);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int w0, r0, bad;
      wait_idle("t6");
      awvalid = 1; awaddr = 32'h50; wvalid = 1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
      step();
      awvalid = 0; wvalid = 0;
      arvalid = 1; araddr = 32'h60;
      step();
      arvalid = 0;
      checks++;
      if (bvalid !== 1'b1 || ren !== 1'b1)
         $display("FAIL t6_setup bvalid=%0b ren=%0b exp=1/1", bvalid, ren);
      else passes++;
      rst = 1;
      step();
      checks++;
      if (outs_c !== '0) $display("FAIL t6_rst_outputs got=%h exp=0", outs_c);
      else passes++;
      rst = 0;
      model_reset();
      w0 = wen_cnt; r0 = ren_cnt; bad = 0;
      bready = 1; rready = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (wen || ren || bvalid || rvalid) bad++;
      end
      bready = 0; rready = 0;
      checks++;
      if (bad != 0 || wen_cnt != w0 || ren_cnt != r0)
         $display("FAIL t6_quiet bad=%0d wens=%0d rens=%0d exp=0/0/0", bad, wen_cnt - w0, ren_cnt - r0);
      else passes++;
      wait_idle("t6b");
      arvalid = 1; araddr = 32'h50;
      step();
      arvalid = 0;
      step();
      checks++;
      if (rvalid !== 1'b1 || rdata !== mem_model[8'h14])
         $display("FAIL t6_readback rvalid=%0b rdata=%h exp=1/%h", rvalid, rdata, mem_model[8'h14]);
      else passes++;
      rready = 1;
      step();
      rready = 0;
   endtask

   initial begin
      test_reset();
      test_write_same_cycle();
      test_w_first();
      test_partial_strobe();
      test_read_stall();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
